// File: rtl/puf_challenge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : puf_challenge_ctrl
// Purpose  : Arbiter-PUF sequencer (relax / launch / sample per evaluation).
//            Build macro PUF_MAJORITY_VOTE_EN adds VOTES-way majority voting.
// Revision : 1.0
// ============================================================================
module puf_challenge_ctrl #(
  parameter int CHAL_W = 64,
  parameter int SETTLE = 8,
  parameter int VOTES  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CHAL_W-1:0] chal_in,
  input  logic              chal_valid,
  output logic              chal_ready,
  output logic [CHAL_W-1:0] challenge,
  output logic              launch,
  input  logic              arb_out,
  output logic              resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_unstable
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RELAX  = 3'd1,
    S_LAUNCH = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(SETTLE - 1);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("puf_challenge_ctrl: SETTLE must be 1..255");
  end
  if (VOTES < 1 || VOTES > 15 || (VOTES % 2) == 0) begin : g_bad_votes
    $error("puf_challenge_ctrl: VOTES must be odd, 1..15");
  end

  state_t              state_q, state_d;
  logic [7:0]          phase_q, phase_d;
  logic [CHAL_W-1:0]   challenge_q, challenge_d;
  logic                launch_q, launch_d;
  logic                resp_q, resp_d;
  logic                resp_valid_q, resp_valid_d;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam int             CNT_W  = $clog2(VOTES + 1);
  localparam logic [CNT_W-1:0] N_EVAL = CNT_W'(VOTES);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(VOTES / 2);

  logic [CNT_W-1:0] ones_q, ones_d, evals_q, evals_d;
  logic [CNT_W-1:0] ones_inc, evals_inc;
  logic             resp_unstable_q, resp_unstable_d;

  assign ones_inc      = ones_q + CNT_W'(arb_out);
  assign evals_inc     = evals_q + CNT_W'(1);
  assign resp_unstable = resp_unstable_q;
`else
  assign resp_unstable = 1'b0;
`endif

  // Gated by rst_n so the host never sees ready while the block is held in reset.
  assign chal_ready = rst_n && (state_q == S_IDLE);
  assign challenge  = challenge_q;
  assign launch     = launch_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    challenge_d  = challenge_q;
    launch_d     = launch_q;
    resp_d       = resp_q;
    resp_valid_d = resp_valid_q;
`ifdef PUF_MAJORITY_VOTE_EN
    ones_d          = ones_q;
    evals_d         = evals_q;
    resp_unstable_d = resp_unstable_q;
`endif
    case (state_q)
      S_IDLE: begin
        launch_d = 1'b0;
        if (chal_valid) begin
          challenge_d = chal_in;
          phase_d     = '0;
          state_d     = S_RELAX;
`ifdef PUF_MAJORITY_VOTE_EN
          ones_d  = '0;
          evals_d = '0;
`endif
        end
      end
      S_RELAX: begin
        if (phase_q == PHASE_LAST) begin
          phase_d  = '0;
          launch_d = 1'b1;
          state_d  = S_LAUNCH;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_LAUNCH: begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          state_d = S_SAMPLE;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        launch_d = 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
        ones_d  = ones_inc;
        evals_d = evals_inc;
        if (evals_inc == N_EVAL) begin
          resp_d          = (ones_inc > HALF);
          resp_unstable_d = (ones_inc != '0) && (ones_inc != N_EVAL);
          resp_valid_d    = 1'b1;
          state_d         = S_DONE;
        end else begin
          state_d = S_RELAX;
        end
`else
        resp_d       = arb_out;
        resp_valid_d = 1'b1;
        state_d      = S_DONE;
`endif
      end
      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        launch_d     = 1'b0;
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      challenge_q  <= '0;
      launch_q     <= 1'b0;
      resp_q       <= 1'b0;
      resp_valid_q <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      ones_q          <= '0;
      evals_q         <= '0;
      resp_unstable_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      challenge_q  <= challenge_d;
      launch_q     <= launch_d;
      resp_q       <= resp_d;
      resp_valid_q <= resp_valid_d;
`ifdef PUF_MAJORITY_VOTE_EN
      ones_q          <= ones_d;
      evals_q         <= evals_d;
      resp_unstable_q <= resp_unstable_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_puf_challenge_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_puf_challenge_ctrl
// Purpose  : Directed self-checking bench for puf_challenge_ctrl (SETTLE=8 and
//            SETTLE=1 instances); voting cases under PUF_MAJORITY_VOTE_EN.
// Revision : 1.0
// ============================================================================
module tb_puf_challenge_ctrl;

  localparam int W   = 64;
  localparam int S_A = 8;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int N_EV = 5;
`else
  localparam int N_EV = 1;
`endif
  localparam int LAT_A = N_EV * (2 * S_A + 1) + 1;
  localparam int LAT_B = N_EV * 3 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] a_chal_in, a_challenge;
  logic         a_chal_valid, a_chal_ready, a_launch, a_arb;
  logic         a_resp, a_resp_valid, a_resp_ready, a_unst;
  logic [W-1:0] b_chal_in, b_challenge;
  logic         b_chal_valid, b_chal_ready, b_launch, b_arb;
  logic         b_resp, b_resp_valid, b_resp_ready, b_unst;

  puf_challenge_ctrl #(.CHAL_W(W), .SETTLE(S_A), .VOTES(5)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .chal_in(a_chal_in), .chal_valid(a_chal_valid),
    .chal_ready(a_chal_ready), .challenge(a_challenge), .launch(a_launch),
    .arb_out(a_arb), .resp(a_resp), .resp_valid(a_resp_valid),
    .resp_ready(a_resp_ready), .resp_unstable(a_unst)
  );

  puf_challenge_ctrl #(.CHAL_W(W), .SETTLE(1), .VOTES(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .chal_in(b_chal_in), .chal_valid(b_chal_valid),
    .chal_ready(b_chal_ready), .challenge(b_challenge), .launch(b_launch),
    .arb_out(b_arb), .resp(b_resp), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_unstable(b_unst)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pat bit k is the arb_out level presented during evaluation k.
  typedef struct {
    logic [W-1:0] chal;
    logic [4:0]   pat;
    logic         exp_resp;
    logic         exp_unst;
  } vec_t;

  vec_t vecs[4];

  task automatic run_eval(input vec_t v);
    int   c, first_hi, first_fall, lat, k, busy_ready;
    logic prev;
    @(negedge clk);
    check("ready_idle", a_chal_ready, 1'b1);
    a_chal_in    = v.chal;
    a_chal_valid = 1'b1;
    a_arb        = v.pat[0];
    @(negedge clk);
    a_chal_valid = 1'b0;
    a_chal_in    = ~v.chal;
    check("chal_load", a_challenge, v.chal);
    c = 1; first_hi = 0; first_fall = 0; lat = 0; k = 0; busy_ready = 0; prev = 1'b0;
    while (lat == 0 && c <= 400) begin
      if (a_launch && first_hi == 0) first_hi = c;
      if (!a_launch && prev) begin
        if (first_fall == 0) first_fall = c;
        k++;
        if (k < 5) a_arb = v.pat[k];
      end
      prev = a_launch;
      if (a_chal_ready) busy_ready++;
      if (a_resp_valid) begin
        lat = c;
      end else begin
        a_chal_valid = (c % 5 == 2);
        @(negedge clk);
        c++;
      end
    end
    a_chal_valid = 1'b0;
    check("latency", lat, LAT_A);
    check("relax_len", first_hi - 1, S_A);
    check("launch_len", first_fall - first_hi, S_A + 1);
    check("ready_busy", busy_ready, 0);
    check("resp", a_resp, v.exp_resp);
    check("unstable", a_unst, v.exp_unst);
    check("chal_hold", a_challenge, v.chal);
    check("launch_done", a_launch, 1'b0);
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    check("valid_drop", a_resp_valid, 1'b0);
    check("ready_back", a_chal_ready, 1'b1);
    check("chal_idle_hold", a_challenge, v.chal);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c, seen;
    logic r0;

`ifdef PUF_MAJORITY_VOTE_EN
    vecs[0] = '{64'hA5A5_0F0F_1234_5678, 5'b01101, 1'b1, 1'b1};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'b00000, 1'b0, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0001, 5'b11111, 1'b1, 1'b0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 5'b00010, 1'b0, 1'b1};
`else
    vecs[0] = '{64'hA5A5_0F0F_1234_5678, 5'b11111, 1'b1, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 5'b00000, 1'b0, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0001, 5'b00001, 1'b1, 1'b0};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 5'b11110, 1'b0, 1'b0};
`endif

    rst_n = 1'b0;
    a_chal_in = '0; a_chal_valid = 1'b0; a_arb = 1'b0; a_resp_ready = 1'b0;
    b_chal_in = '0; b_chal_valid = 1'b0; b_arb = 1'b0; b_resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", a_chal_ready, 1'b0);
    check("rst_launch", a_launch, 1'b0);
    check("rst_valid", a_resp_valid, 1'b0);
    check("rst_chal", a_challenge, 64'd0);
    check("rst_resp", a_resp, 1'b0);
    check("rst_unst", a_unst, 1'b0);
    rst_n = 1'b1;
    #1;
    check("ready_release", a_chal_ready, 1'b1);

    foreach (vecs[i]) run_eval(vecs[i]);

    // Response held in DONE while the consumer stalls; host pulses ignored.
    @(negedge clk);
    a_chal_in = 64'hDEAD_BEEF_0000_1111; a_chal_valid = 1'b1; a_arb = 1'b1;
    @(negedge clk);
    a_chal_valid = 1'b0;
    c = 0;
    while (!a_resp_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("hold_reach", a_resp_valid, 1'b1);
    check("hold_resp_val", a_resp, 1'b1);
    r0 = a_resp;
    for (int i = 0; i < 20; i++) begin
      a_chal_valid = i[0];
      a_chal_in    = 64'h1111_1111_1111_1111 * (i + 1);
      @(negedge clk);
      check("hold_valid", a_resp_valid, 1'b1);
      check("hold_resp", a_resp, r0);
      check("hold_ready", a_chal_ready, 1'b0);
    end
    a_chal_valid = 1'b0;
    a_resp_ready = 1'b1;
    @(negedge clk);
    a_resp_ready = 1'b0;
    check("hold_release_valid", a_resp_valid, 1'b0);
    check("hold_release_ready", a_chal_ready, 1'b1);
    check("hold_chal", a_challenge, 64'hDEAD_BEEF_0000_1111);

    // Reset in the middle of the launch phase.
    @(negedge clk);
    a_chal_in = 64'h5555_AAAA_5555_AAAA; a_chal_valid = 1'b1; a_arb = 1'b1;
    @(negedge clk);
    a_chal_valid = 1'b0;
    c = 0;
    while (!a_launch && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("mid_launch", a_launch, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_launch", a_launch, 1'b0);
    check("abort_ready", a_chal_ready, 1'b0);
    check("abort_chal", a_challenge, 64'd0);
    check("abort_valid", a_resp_valid, 1'b0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_resp_valid || a_launch) seen++;
    end
    check("abort_quiet", seen, 0);
    check("abort_ready_back", a_chal_ready, 1'b1);
    run_eval(vecs[0]);

    // Minimum settle time on the second instance.
    @(negedge clk);
    b_chal_in = 64'h0F0F_F0F0_3C3C_C3C3; b_chal_valid = 1'b1; b_arb = 1'b1;
    @(negedge clk);
    b_chal_valid = 1'b0;
    check("b_chal_load", b_challenge, 64'h0F0F_F0F0_3C3C_C3C3);
    check("b_launch_c1", b_launch, 1'b0);
    @(negedge clk);
    check("b_launch_c2", b_launch, 1'b1);
    @(negedge clk);
    check("b_launch_c3", b_launch, 1'b1);
    c = 3;
    while (!b_resp_valid && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("b_latency", c, LAT_B);
    check("b_resp", b_resp, 1'b1);
    check("b_unst", b_unst, 1'b0);
    check("b_launch_done", b_launch, 1'b0);
    b_resp_ready = 1'b1;
    @(negedge clk);
    b_resp_ready = 1'b0;
    check("b_valid_drop", b_resp_valid, 1'b0);
    check("b_ready_back", b_chal_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
